// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg: shared UART state encodings and oversampling constants.
package uart_rx_core_pkg;
    localparam int OS  = 16;
    localparam int MID = OS / 2 - 1;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4,
        PARITY = 3'd5
    } state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick, one clk pulse every CLK_FREQ/(BAUD*OS) clocks.
module uart_baud_tick #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int OS       = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = CLK_FREQ / (BAUD * OS);
    localparam int W   = $clog2(DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst) cnt <= '0;
        else      cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver, 16x oversampling with mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 rx_busy
);
    localparam int DIV = CLK_FREQ / (BAUD * OS);
    localparam int NW  = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam state_t LAST = PARITY;
`else
    localparam state_t LAST = STOP;
`endif
    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_core: CLK_FREQ/(BAUD*16) must be >= 2");
    end
    state_t               state;
    logic [3:0]           s;
    logic [NW-1:0]        n;
    logic [DATA_BITS-1:0] sh;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 perr;
`endif
    uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OS(OS)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );
    assign rx_busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            s          <= '0;
            n          <= '0;
            sh         <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            perr       <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: if (!rx) begin
                    state <= START;
                    s     <= '0;
                end
                START: if (tick) begin
                    if (s == 4'(MID)) begin
                        state <= rx ? IDLE : DATA;
                        s     <= '0;
                        n     <= '0;
                    end else s <= s + 1'b1;
                end
                DATA: if (tick) begin
                    if (s == 4'(OS - 1)) begin
                        sh <= {rx, sh[DATA_BITS-1:1]};
                        n  <= n + 1'b1;
                        s  <= '0;
                        if (n == NW'(DATA_BITS - 1)) state <= LAST;
                    end else s <= s + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    if (s == 4'(OS - 1)) begin
                        perr  <= ^sh ^ rx;
                        s     <= '0;
                        state <= STOP;
                    end else s <= s + 1'b1;
                end
`endif
                STOP: if (tick) begin
                    if (s == 4'(OS - 1)) begin
                        s <= '0;
                        if (rx) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (perr) parity_err <= 1'b1;
                            else begin
                                data_out   <= sh;
                                data_valid <= 1'b1;
                            end
`else
                            data_out   <= sh;
                            data_valid <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else s <= s + 1'b1;
                end
                // a line held low after a bad stop bit must not start a new frame
                BREAK: if (rx) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
